// File: rtl/pwm_capture.sv
// pwm_capture: Wishbone-slave PWM measurement block.
// Samples one asynchronous PWM waveform and reports its period and high time
// in prescaled clock ticks, plus a capture counter and sticky status flags.
// Optional build macro PWMCAP_IRQ_EN adds CTRL.IE and the irq_o output.
module pwm_capture #(
    parameter int CW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        pwm_i
`ifdef PWMCAP_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HIGH = 2'd2,
        S_LOW  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_STATUS   = 3'd1;
    localparam logic [2:0] A_PRESCALE = 3'd2;
    localparam logic [2:0] A_PERIOD   = 3'd3;
    localparam logic [2:0] A_HIGH     = 3'd4;
    localparam logic [2:0] A_EDGES    = 3'd5;

    // Control registers
    logic              en;
    logic              pol;
    logic              ie;
    logic [15:0]       prescale;

    // Input conditioning
    logic [SYNC_STAGES-1:0] sync;
    logic              prev;
    logic              level;
    logic              rise;
    logic              fall;

    // Measurement datapath
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [CW-1:0]     hi;
    logic [CW-1:0]     period;
    logic [CW-1:0]     high_time;
    logic [15:0]       pre;
    logic [15:0]       pre_lim;
    logic [15:0]       edges;
    logic              running;
    logic              tick;
    logic              cnt_sat;
    logic              capture;
    logic              ovf_set;

    // Status flags
    logic              valid;
    logic              ovr;
    logic              ovf;

    // Bus decode
    logic              req;
    logic              wr;
    logic [2:0]        idx;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_prescale;
    logic [31:0]       rdata;

    // Address bits above the page offset, byte lanes 2-3 and the upper data
    // half carry nothing for this block.
    logic              unused;
    assign unused = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

    // ------------------------------------------------------------------
    // Input synchronizer, polarity and edge detection
    // ------------------------------------------------------------------
    assign level = sync[SYNC_STAGES-1] ^ pol;
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

    // Shift pwm_i through the synchronizer and keep the previous level
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_i};
            prev <= level;
        end
    end

    // ------------------------------------------------------------------
    // Tick generation and saturating measurement counter
    // ------------------------------------------------------------------
    // The edge cycle itself may carry a tick, so results use cnt_next; this
    // makes a spacing of d clocks read floor(d / (PRESCALE+1)).
    assign running  = en && ((state == S_HIGH) || (state == S_LOW));
    assign tick     = running && (pre == pre_lim);
    assign cnt_sat  = (cnt == CNT_MAX);
    assign cnt_next = (tick && !cnt_sat) ? cnt + CNT_ONE : cnt;
    assign ovf_set  = tick && cnt_sat;
    assign capture  = en && (state == S_LOW) && rise;

    // Capture FSM: counters, latched high time and published results
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pre       <= '0;
            pre_lim   <= '0;
            hi        <= '0;
            period    <= '0;
            high_time <= '0;
            edges     <= '0;
        end else if (!en) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pre     <= '0;
            pre_lim <= prescale;
        end else begin
            case (state)
                S_IDLE: begin
                    state   <= S_ARM;
                    edges   <= '0;
                    cnt     <= '0;
                    pre     <= '0;
                    pre_lim <= prescale;
                end
                S_ARM: begin
                    if (rise) begin
                        state   <= S_HIGH;
                        cnt     <= '0;
                        pre     <= '0;
                        pre_lim <= prescale;
                    end
                end
                S_HIGH: begin
                    cnt <= cnt_next;
                    pre <= tick ? 16'd0 : pre + 16'd1;
                    if (tick) begin
                        pre_lim <= prescale;
                    end
                    if (fall) begin
                        hi    <= cnt_next;
                        state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        period    <= cnt_next;
                        high_time <= hi;
                        edges     <= edges + 16'd1;
                        cnt       <= '0;
                        pre       <= '0;
                        pre_lim   <= prescale;
                        state     <= S_HIGH;
                    end else begin
                        cnt <= cnt_next;
                        pre <= tick ? 16'd0 : pre + 16'd1;
                        if (tick) begin
                            pre_lim <= prescale;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky status flags; a new capture or overflow wins over a w1c
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            valid <= 1'b0;
            ovr   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (capture) begin
                valid <= 1'b1;
            end else if (wr_status && wbs_dat_i[0]) begin
                valid <= 1'b0;
            end
            if (capture && valid) begin
                ovr <= 1'b1;
            end else if (wr_status && wbs_dat_i[1]) begin
                ovr <= 1'b0;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (wr_status && wbs_dat_i[2]) begin
                ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wishbone slave
    // ------------------------------------------------------------------
    assign req         = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
    assign wr          = req && wbs_we_i;
    assign idx         = wbs_adr_i[4:2];
    assign wr_ctrl     = wr && (idx == A_CTRL) && wbs_sel_i[0];
    assign wr_status   = wr && (idx == A_STATUS) && wbs_sel_i[0];
    assign wr_prescale = wr && (idx == A_PRESCALE);

    // Single-cycle ack with read data registered alongside it
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'd0;
        end
    end

`ifdef PWMCAP_IRQ_EN
    // Control and prescale registers, byte-lane gated
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en       <= 1'b0;
            pol      <= 1'b0;
            ie       <= 1'b0;
            prescale <= '0;
        end else begin
            if (wr_ctrl) begin
                en  <= wbs_dat_i[0];
                pol <= wbs_dat_i[1];
                ie  <= wbs_dat_i[2];
            end
            if (wr_prescale && wbs_sel_i[0]) begin
                prescale[7:0] <= wbs_dat_i[7:0];
            end
            if (wr_prescale && wbs_sel_i[1]) begin
                prescale[15:8] <= wbs_dat_i[15:8];
            end
        end
    end

    // Interrupt follows VALID gated by IE, one register later
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= valid && ie;
        end
    end
`else
    assign ie = 1'b0;

    // Control and prescale registers, byte-lane gated
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            en       <= 1'b0;
            pol      <= 1'b0;
            prescale <= '0;
        end else begin
            if (wr_ctrl) begin
                en  <= wbs_dat_i[0];
                pol <= wbs_dat_i[1];
            end
            if (wr_prescale && wbs_sel_i[0]) begin
                prescale[7:0] <= wbs_dat_i[7:0];
            end
            if (wr_prescale && wbs_sel_i[1]) begin
                prescale[15:8] <= wbs_dat_i[15:8];
            end
        end
    end
`endif

    // Register read multiplexer
    always_comb begin
        rdata = 32'd0;
        case (idx)
            A_CTRL:     rdata = {29'd0, ie, pol, en};
            A_STATUS:   rdata = {26'd0, state, level, ovf, ovr, valid};
            A_PRESCALE: rdata = {16'd0, prescale};
            A_PERIOD:   rdata = 32'(period);
            A_HIGH:     rdata = 32'(high_time);
            A_EDGES:    rdata = {16'd0, edges};
            default:    rdata = 32'd0;
        endcase
    end

endmodule
